// File: rtl/pwm_pkg.sv
// Shared types and width helpers for the multi-channel PWM generator.
// Imported by the timebase, the top level and anything that sizes the write bus.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Counter width: holds 0 .. interval-1.
  function automatic int pwm_cw(input int interval);
    return (interval > 1) ? $clog2(interval) : 1;
  endfunction

  // Duty width: holds 0 .. interval so full-on is representable.
  function automatic int pwm_dw(input int interval);
    return $clog2(interval + 1);
  endfunction

  // Channel-select width, never narrower than one bit.
  function automatic int pwm_aw(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Duty-write bus between the fade/sequencer logic (master) and pwm_multi (slave).
// One strobe, a channel select and the new duty value in clock cycles.
interface pwm_multi_if #(
  parameter int AW = 2,
  parameter int DW = 11
);
  logic          wr_en;
  logic [AW-1:0] wr_ch;
  logic [DW-1:0] wr_duty;

  modport master (output wr_en, output wr_ch, output wr_duty);
  modport slave  (input  wr_en, input  wr_ch, input  wr_duty);
endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: edge- or center-aligned counter, period-boundary commit
// strobe for the channel duty registers, and the registered period_start pulse.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter int CW           = pwm_cw(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          mode_center,
  output logic [CW-1:0] count,
  output logic          commit,
  output logic          period_start
);

  localparam logic [CW-1:0] LAST = CW'(PWM_INTERVAL - 1);

  logic [CW-1:0] count_q, count_d;
  dir_t          dir_q, dir_d;
  pwm_mode_t     mode_q, mode_d;
  logic          period_start_q, period_start_d;
  logic          terminal;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the if/else tree can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    mode_d  = mode_q;

    // Edge mode never leaves DIR_UP, so only the center mode needs dir here.
    terminal = (mode_q == PWM_EDGE) ? (count_q == LAST)
                                    : ((count_q == '0) && (dir_q == DIR_DOWN));

    // While disabled the duty/mode registers track their inputs every cycle.
    commit = !enable || terminal;

    if (!enable || terminal) begin
      count_d = '0;
      dir_d   = DIR_UP;
    end else if (mode_q == PWM_CENTER) begin
      if (dir_q == DIR_UP) begin
        // Dwell one extra cycle at the top while turning around.
        if (count_q == LAST) dir_d = DIR_DOWN;
        else                 count_d = count_q + 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end else begin
      count_d = count_q + 1'b1;
    end

    if (commit) mode_d = mode_center ? PWM_CENTER : PWM_EDGE;

    period_start_d = enable && (count_q == '0) && (dir_q == DIR_UP);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q        <= '0;
      dir_q          <= DIR_UP;
      mode_q         <= PWM_EDGE;
      period_start_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      dir_q          <= dir_d;
      mode_q         <= mode_d;
      period_start_q <= period_start_d;
    end
  end

  assign count        = count_q;
  assign period_start = period_start_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel LED PWM: one shared timebase, per-channel double-buffered duty
// (shadow written any time, active loaded only at commit) and registered outputs.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int                  PWM_INTERVAL = 1200,
  parameter int                  CHANNELS     = 3,
  parameter logic [CHANNELS-1:0] INVERT       = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                mode_center,
  pwm_multi_if.slave          wr_bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam int CW = pwm_cw(PWM_INTERVAL);
  localparam int DW = pwm_dw(PWM_INTERVAL);
  localparam int AW = pwm_aw(CHANNELS);

  logic [CW-1:0] count;
  logic [DW-1:0] count_ext;
  logic          commit;

  pwm_timebase #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .CW           (CW)
  ) u_timebase (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mode_center  (mode_center),
    .count        (count),
    .commit       (commit),
    .period_start (period_start)
  );

  // Duty is one bit wider than the count, so duty >= P is always-on.
  assign count_ext = DW'(count);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DW-1:0] shadow_q, shadow_d;
    logic [DW-1:0] active_q, active_d;
    logic          pwm_q, pwm_d;

    always_comb begin
      shadow_d = shadow_q;
      if (wr_bus.wr_en && (wr_bus.wr_ch == AW'(i))) shadow_d = wr_bus.wr_duty;

      // A write on the commit edge lands in shadow only; active takes the old shadow.
      active_d = commit ? shadow_q : active_q;

      pwm_d = (enable && (count_ext < active_q)) ^ INVERT[i];
    end

    // NOTE: shadow and active are plain registers, not a RAM, and must come
    // out of reset at zero duty, so they are reset alongside the output flop.
    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_q <= '0;
        active_q <= '0;
        pwm_q    <= INVERT[i];
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
        pwm_q    <= pwm_d;
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel LED PWM generator; next generation of the single-channel fade PWM. One shared timebase drives CHANNELS comparators. Each channel has a double-buffered duty register committed only at period boundaries, so duty updates are glitch-free. Adds true 0 %/100 % duty, per-channel output inversion and an edge-/center-aligned mode. Sits between fade/sequencer logic and the RGB LED pins.

## Interface
- PWM_INTERVAL, 1200: timebase length P in clk cycles (100 µs at 12 MHz); ≥ 2
- CHANNELS, 3: number of PWM outputs; ≥ 1
- INVERT, '0: CHANNELS-bit mask; bit i = 1 makes pwm_out[i] active-low
- Derived: CW = $clog2(PWM_INTERVAL); DW = $clog2(PWM_INTERVAL+1); AW = max(1, $clog2(CHANNELS))

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run timebase; low holds counter at 0
- mode_center  in  1  0 = edge-aligned, 1 = center-aligned; latched at commit
- wr_en  in  1  duty write strobe
- wr_ch  in  AW  target channel; values ≥ CHANNELS ignored
- wr_duty  in  DW  duty in cycles of high time per P
- pwm_out  out  CHANNELS  registered PWM outputs
- period_start  out  1  one-cycle pulse aligned with first output cycle of each period

## Operation
- State: count[CW], dir (up/down), mode_q, shadow[i][DW], active[i][DW].
- Write: wr_en with wr_ch < CHANNELS sets shadow[wr_ch] <= wr_duty next edge; never touches active directly.
- Edge mode: count 0,1,…,P-1,0,… (period P). Terminal cycle: count == P-1.
- Center mode: count 0→P-1 (dir up), holds P-1 one extra cycle switching dir down, then P-1→0 (sequence length 2P). Terminal cycle: count == 0 with dir down. Pulse is centred on the period boundary.
- Commit: on the edge ending a terminal cycle (enable high), active <= shadow for all channels, mode_q <= mode_center, count <= 0, dir <= up. A write on that same edge goes to shadow only; active takes the pre-write shadow.
- enable low: count <= 0, dir <= up, active <= shadow and mode_q <= mode_center every cycle; pwm_out held at INVERT. Re-enable starts a fresh period from count 0 with the latest shadow.
- Output: pwm_out[i] <= ((enable && count < active[i]) ? 1 : 0) XOR INVERT[i]. duty 0 → never active; duty ≥ P → always active (no clamp logic; compare saturates).
- period_start <= enable && count == 0 && dir == up.
- Changing mode_center mid-period has no effect until next commit.

## Timing
- Reset: count 0, dir up, mode_q 0, all shadow/active 0, pwm_out = INVERT, period_start 0.
- pwm_out and period_start are registered one cycle after the count they decode; both lag count identically.
- Write-to-effect latency: visible from the first period after the next commit; at most one period plus one cycle.
- Edge mode: high time = min(duty, P) cycles per P. Center mode: 2·min(duty, P) cycles per 2P.
- Reset mid-period overrides everything, including a coincident wr_en or terminal cycle.
- period_start also fires one cycle after enable rises (count already 0).

## Structure
- Package pwm_pkg: pwm_mode_t enum {PWM_EDGE, PWM_CENTER}, dir_t enum {DIR_UP, DIR_DOWN}, shared width helper functions.
- Sub-module pwm_timebase: count, dir, mode_q, terminal/commit strobe, period_start. pwm_multi instantiates it once plus a generate loop of shadow/active/compare per channel.

## Test plan
(P = 10, CHANNELS = 3, INVERT = 3'b100)
- Reset asserted 3 cycles → pwm_out = 3'b100, period_start = 0; after release with enable low, unchanged.
- Write ch0 = 3 while disabled, raise enable → pwm_out[0] high 3 of every 10 cycles; period_start every 10 cycles, coincident with first high cycle.
- Duties ch0 = 0, ch1 = 10, ch2 = 15 → ch0 always 0, ch1 always 1, ch2 always 0 (inverted full-on).
- ch1 = 5 running; write 7 at count 4 → current period 5 high, following periods 7 high; write coincident with terminal cycle lands one period later.
- mode_center = 1, ch0 = 3 → period 20 cycles, 6 contiguous high cycles straddling each period_start; toggling mode mid-period changes nothing until boundary.
- wr_ch = 3 write ignored (all duties unchanged); reset mid-period → outputs return to 3'b100 next cycle, period restarts from count 0.
